// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the board RGB LED: latches the winner's colour and duty,
// shows it via PWM for HOLD_CYCLES, then keeps the LED dark for GAP_CYCLES.
module rgb_led_arbiter #(
  parameter int N_REQ       = 3,
  parameter int PWM_BITS    = 8,
  parameter int HOLD_CYCLES = 12000000,
  parameter int GAP_CYCLES  = 1200000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [3*N_REQ-1:0]           req_color,
  input  logic [PWM_BITS*N_REQ-1:0]    req_duty,
  output logic [N_REQ-1:0]             grant,
  output logic                         done,
  output logic                         busy,
  output logic                         red,
  output logic                         green,
  output logic                         blue
);

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LAST_RST  = LW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                r_state;
  logic [HW-1:0]         r_hold;
  logic [GW-1:0]         r_gap;
  logic [LW-1:0]         r_last;
  logic [PWM_BITS-1:0]   r_pwm;
  logic [PWM_BITS-1:0]   r_duty;
  logic [2:0]            r_color;

  logic                  w_found;
  logic [LW-1:0]         w_win;
  logic [LW-1:0]         w_cand;
  logic [2:0]            w_color [N_REQ];
  logic [PWM_BITS-1:0]   w_duty  [N_REQ];
  logic [2:0]            w_lit;

  genvar g;
  for (g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_color[g] = req_color[3*g +: 3];
    assign w_duty[g]  = req_duty[PWM_BITS*g +: PWM_BITS];
  end

  // Candidates are visited from last+1 upward, so the first hit is the round-robin winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand  = LW'((int'(r_last) + k) % N_REQ);
      w_win   = (!w_found && req[w_cand]) ? w_cand : w_win;
      w_found = w_found | req[w_cand];
    end
  end

  assign w_lit = ((r_state == S_SHOW) && (r_pwm < r_duty)) ? r_color : 3'b000;

  // Single FSM: arbitration, hold/gap timing, free-running PWM and the lagged LED pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= {HW{1'b0}};
      r_gap   <= {GW{1'b0}};
      r_last  <= LAST_RST;
      r_pwm   <= {PWM_BITS{1'b0}};
      r_duty  <= {PWM_BITS{1'b0}};
      r_color <= 3'b000;
      grant   <= {N_REQ{1'b0}};
      done    <= 1'b0;
      busy    <= 1'b0;
      red     <= 1'b1;
      green   <= 1'b1;
      blue    <= 1'b1;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      red   <= ~w_lit[2];
      green <= ~w_lit[1];
      blue  <= ~w_lit[0];
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_SHOW;
            r_last  <= w_win;
            r_color <= w_color[w_win];
            r_duty  <= w_duty[w_win];
            grant   <= N_REQ'(1) << w_win;
            r_hold  <= HOLD_LOAD;
            busy    <= 1'b1;
            done    <= (HOLD_CYCLES == 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHOW: begin
          if (r_hold == {HW{1'b0}}) begin
            grant <= {N_REQ{1'b0}};
            done  <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_GAP;
              r_gap   <= GAP_LOAD;
            end
          end else begin
            r_hold <= r_hold - HW'(1);
            done   <= (r_hold == HW'(1));
          end
        end
        S_GAP: begin
          if (r_gap == {GW{1'b0}}) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          grant   <= {N_REQ{1'b0}};
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter: a timeline model (grant edge plus elapsed
// cycles) predicts every output each cycle; directed scenarios pin literal values.
module tb_rgb_led_arbiter;
  localparam int N  = 3;
  localparam int PB = 2;
  localparam int H  = 8;
  localparam int G  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] req_color = '0;
  logic [PB*N-1:0] req_duty = '0;
  logic [N-1:0]   grant;
  logic           done, busy, red, green, blue;

  always #5 clk = ~clk;

  rgb_led_arbiter #(.N_REQ(N), .PWM_BITS(PB), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .req_color(req_color), .req_duty(req_duty),
    .grant(grant), .done(done), .busy(busy), .red(red), .green(green), .blue(blue)
  );

  // Model: t = edges since reset, tg = edge at which the current/last grant was made.
  int         t, tg, m_owner, m_last, m_duty, m_pwm, cand;
  bit         m_valid = 1'b0, found;
  logic [2:0] m_col;
  logic [2:0] e_grant, e_rgb;
  logic       e_done, e_busy;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; tg = -1; m_last = N - 1; m_pwm = 0; e_rgb = 3'b111; m_valid = 1'b1;
    end else if (m_valid) begin
      t = t + 1;
      // pins show what the previous cycle displayed
      if (tg >= 0 && (t - 1 - tg) < H)
        e_rgb = ~(m_col & {3{m_pwm < m_duty}});
      else
        e_rgb = 3'b111;
      m_pwm = (m_pwm + 1) % (1 << PB);
      if ((tg < 0 || (t - 1 - tg) >= H + G) && req != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          cand = (m_last + k) % N;
          if (!found && ((req >> cand) & 3'b001) != 3'b000) begin
            found = 1'b1; m_owner = cand;
          end
        end
        m_last = m_owner;
        m_col  = 3'(req_color >> (3 * m_owner));
        m_duty = int'(2'(req_duty >> (PB * m_owner)));
        tg = t;
      end
    end
    if (tg >= 0 && (t - tg) < H) begin
      e_grant = 3'(1 << m_owner); e_done = ((t - tg) == H - 1); e_busy = 1'b1;
    end else if (tg >= 0 && (t - tg) < H + G) begin
      e_grant = 3'b000; e_done = 1'b0; e_busy = 1'b1;
    end else begin
      e_grant = 3'b000; e_done = 1'b0; e_busy = 1'b0;
    end
  end

  int n_chk = 0, n_err = 0;
  int n_rlow, n_glow, n_blow, n_done, n_busy;
  logic [2:0] prev_grant = 3'b000;
  logic [2:0] q_gr[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      chk("grant", 8'(grant), 8'(e_grant));
      chk("done",  8'(done),  8'(e_done));
      chk("busy",  8'(busy),  8'(e_busy));
      chk("rgb",   8'({red, green, blue}), 8'(e_rgb));
    end
    if (!red)   n_rlow++;
    if (!green) n_glow++;
    if (!blue)  n_blow++;
    if (done)   n_done++;
    if (busy)   n_busy++;
    if (grant != 3'b000 && prev_grant == 3'b000) q_gr.push_back(grant);
    prev_grant = grant;
  endtask

  task automatic clr();
    n_rlow = 0; n_glow = 0; n_blow = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic set_req(input int i, input logic [2:0] col, input logic [1:0] duty);
    req_color = (req_color & ~(9'b000000111 << (3 * i))) | (9'(col) << (3 * i));
    req_duty  = (req_duty & ~(6'b000011 << (PB * i))) | (6'(duty) << (PB * i));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("idle_timeout", 8'(busy), 8'd0);
    tick();
  endtask

  task automatic wait_grants(input int target);
    int n = 0;
    while (q_gr.size() < target && n < 300) begin tick(); n++; end
    chk("grant_timeout", 8'(q_gr.size() >= target), 8'd1);
  endtask

  int base;

  initial begin
    // 1: reset values and first grant
    clr();
    rst = 1'b1; req = 3'($urandom_range(0, 7)); tick(); req = 3'($urandom_range(0, 7)); tick();
    chk("rst_grant", 8'(grant), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_rgb", 8'({red, green, blue}), 8'h07);
    rst = 1'b0;
    set_req(0, 3'b111, 2'd1); set_req(1, 3'b111, 2'd1); set_req(2, 3'b111, 2'd1);
    req = 3'b111; tick();
    chk("first_grant", 8'(grant), 8'h01);
    req = 3'b000; wait_idle();

    // 2: single request, red at duty 3
    clr(); set_req(0, 3'b100, 2'd3); req = 3'b001; tick();
    chk("s2_grant", 8'(grant), 8'h01);
    req = 3'b000; wait_idle();
    chk("s2_red_low", 8'(n_rlow), 8'd6);
    chk("s2_green_low", 8'(n_glow), 8'd0);
    chk("s2_blue_low", 8'(n_blow), 8'd0);
    chk("s2_done", 8'(n_done), 8'd1);
    chk("s2_busy_cycles", 8'(n_busy), 8'd10);

    // 3: round robin
    do_reset();
    base = q_gr.size(); req = 3'b111;
    wait_grants(base + 3);
    req = 3'b101;
    wait_grants(base + 5);
    req = 3'b000; wait_idle();
    chk("rr0", 8'(q_gr[base]),     8'h01);
    chk("rr1", 8'(q_gr[base + 1]), 8'h02);
    chk("rr2", 8'(q_gr[base + 2]), 8'h04);
    chk("rr3", 8'(q_gr[base + 3]), 8'h01);
    chk("rr4", 8'(q_gr[base + 4]), 8'h04);

    // 4: duty extremes
    clr(); set_req(0, 3'b111, 2'd0); req = 3'b001; tick(); req = 3'b000; wait_idle();
    chk("d0_lows", 8'(n_rlow + n_glow + n_blow), 8'd0);
    clr(); set_req(0, 3'b011, 2'd3); req = 3'b001; tick(); req = 3'b000; wait_idle();
    chk("d3_red_low", 8'(n_rlow), 8'd0);
    chk("d3_green_low", 8'(n_glow), 8'd6);
    chk("d3_blue_low", 8'(n_blow), 8'd6);

    // 5: req drop and colour change during SHOW
    clr(); set_req(0, 3'b010, 2'd3); req = 3'b001; tick(); tick();
    req = 3'b000; set_req(0, 3'b101, 2'd0); wait_idle();
    chk("s5_green_low", 8'(n_glow), 8'd6);
    chk("s5_red_low", 8'(n_rlow), 8'd0);
    chk("s5_done", 8'(n_done), 8'd1);
    chk("s5_busy_cycles", 8'(n_busy), 8'd10);

    // 6: reset mid-SHOW
    clr(); set_req(0, 3'b111, 2'd3); set_req(1, 3'b111, 2'd3);
    req = 3'b001; tick(); req = 3'b011; tick(); tick(); tick();
    rst = 1'b1; tick();
    chk("s6_grant", 8'(grant), 8'd0);
    chk("s6_rgb", 8'({red, green, blue}), 8'h07);
    chk("s6_done", 8'(n_done), 8'd0);
    rst = 1'b0; tick();
    chk("s6_regrant", 8'(grant), 8'h01);
    req = 3'b000; wait_idle();

    // random phase
    for (int c = 0; c < 1500; c++) begin
      req       = 3'($urandom_range(0, 7));
      req_color = 9'($urandom());
      req_duty  = 6'($urandom());
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req = 3'b000; wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the board's single RGB LED between several requesters (status sources such as heartbeat, error and activity logic). Round-robin arbitration grants the LED to one requester at a time. The granted colour and brightness are latched and displayed via PWM for a fixed hold time, followed by a dark gap. This block replaces direct LED drive logic: it owns the `red`/`green`/`blue` pins, and all LED sources go through it.

## Interface
- `N_REQ`, 3: number of requesters (2..8).
- `PWM_BITS`, 8: PWM counter and duty width.
- `HOLD_CYCLES`, 12000000: display time per grant, in clk cycles (≥1).
- `GAP_CYCLES`, 1200000: dark time after each grant, in clk cycles (0 allowed).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  per-requester display request, level.
- `req_color`  in  3*N_REQ  requester i at [3i+2:3i]; bit 2 = red, bit 1 = green, bit 0 = blue; 1 = channel lit.
- `req_duty`  in  PWM_BITS*N_REQ  requester i at [PWM_BITS*(i+1)-1:PWM_BITS*i]; brightness.
- `grant`  out  N_REQ  one-hot owner during SHOW; 0 otherwise.
- `done`  out  1  one-cycle pulse in the last SHOW cycle.
- `busy`  out  1  high in SHOW and GAP.
- `red`, `green`, `blue`  out  1 each  LED drive, active-low (1 = off), registered.

## Operation
- FSM has three states: IDLE, SHOW, GAP.
- **IDLE**:
  - If any `req` bit is set, pick the first set bit searching from `last+1` upward, modulo N_REQ.
  - At that edge: latch that requester's colour and duty, set `grant` one-hot, load the hold counter, set `last` to the winner, and enter SHOW.
  - With no request, stay in IDLE.
- **SHOW**:
  - Lasts exactly HOLD_CYCLES cycles. `grant` is held constant.
  - `req` and the colour/duty inputs are ignored; the values latched at grant time are used. A requester dropping `req` does not shorten SHOW.
  - `done` is asserted in the final SHOW cycle.
  - Next state is GAP, or IDLE if GAP_CYCLES = 0.
- **GAP**:
  - Lasts exactly GAP_CYCLES cycles. `grant` = 0 and all LEDs are off.
  - Then returns to IDLE.
- **PWM**:
  - `pwm_cnt` is PWM_BITS wide. It is free-running, wraps at 2^PWM_BITS-1 → 0, and is not realigned at grant.
  - A channel is lit when it is in SHOW, its colour bit = 1, and `pwm_cnt < duty`.
  - duty = 0 means never lit. duty = 2^PWM_BITS-1 means lit for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- **Outputs**: the `red`/`green`/`blue` registers take the inverted lit value.
- **Round-robin pointer**: `last` resets to N_REQ-1, so requester 0 has first priority after reset.
  - `last` updates only on grant.
  - A requester that keeps `req` high is re-granted only after every other active requester has been served.
- **Counters**: the hold and gap counters are sized to fit the parameter values and count down to 0. There is no overflow path.

## Timing
- **Reset** (checked at a posedge with `rst` = 1); after that edge:
  - state = IDLE, `grant` = 0, `done` = 0, `busy` = 0;
  - `red` = `green` = `blue` = 1;
  - `pwm_cnt` = 0, `last` = N_REQ-1.
- Reset mid-SHOW or mid-GAP aborts immediately, with no `done` pulse.
- **Grant latency**: if `req` is seen in IDLE at edge k, then `grant` and `busy` are valid after edge k.
  - The first SHOW cycle is k to k+1.
  - LED pins reflect SHOW starting after edge k+1, one register stage behind `pwm_cnt`/state.
- **End of SHOW**: `done` is high during SHOW cycle number HOLD_CYCLES. `grant` and `busy` (if GAP_CYCLES = 0) fall at the following edge.
- **LED lag**: LED pins stay one cycle behind state at both the start and end of SHOW, so the last lit pixel can appear in the first GAP/IDLE cycle.
- **Back-to-back grants**: the earliest next grant is the edge after returning to IDLE. At least one IDLE cycle separates grants.
- **Request during SHOW/GAP**: `req` changes are invisible; only the `req` value in IDLE matters.

## Test plan
Parameters for all scenarios: N_REQ = 3, PWM_BITS = 2, HOLD_CYCLES = 8, GAP_CYCLES = 2.

1. **Reset values**: assert `rst` for 2 cycles with random `req` → `grant` = 000, `done` = 0, `busy` = 0, rgb = 111; the first grant after release goes to requester 0 when all request.
2. **Single request**: `req` = 001, colour = 100, duty = 3.
   - `grant` = 001 one cycle later, held for 8 cycles, `done` in the 8th cycle.
   - `red` low for 3 of every 4 cycles (lagged by 1); `green` = `blue` = 1 throughout.
   - Then 2 dark GAP cycles with `busy` = 1, then `busy` = 0.
3. **Round robin**: `req` = 111 held constant → grants in order 001, 010, 100, 001.
   - Then `req` = 101 right after requester 2's grant → next grant 001, then 100.
4. **Duty extremes**: colour = 111, duty = 0 → rgb stays 111 for the whole SHOW. Colour = 011, duty = 3 → `green`/`blue` low 6 of 8 SHOW cycles and `red` always 1.
5. **Req drop and colour change during SHOW**: `req` falls and colour changes one cycle after grant → SHOW still lasts 8 cycles with the latched colour, and `done` fires once.
6. **Reset mid-SHOW**: `rst` at SHOW cycle 4 → after that edge `grant` = 000, rgb = 111, no `done`. After release, requester 0 wins again if it is requesting.
